// File: rtl/jts16_busarb.sv
// Purpose: 68000 bus arbiter handing the bus to a peripheral (MCU/DMA) via BR/BG/BGACK.
// Latency: at least 3 cpu_cen ticks from per_req to per_gnt (IDLE->REQ->WAIT_BUS->GRANT).
// Backpressure: a tenure is cut at MAXHOLD ticks (ovr pulse); the CPU then keeps the bus HOLDOFF ticks.
module jts16_busarb #(
    parameter int HOLDOFF = 4,
    parameter int MAXHOLD = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cpu_cen,
    input  logic ASn,
    input  logic BGn,
    output logic BRn,
    output logic BGACKn,
    input  logic per_req,
    output logic per_gnt,
    output logic ovr,
    output logic busy
);

    // A HOLDOFF of 0 still spends one tick in HOLDOFF so the CPU always gets the bus back.
    localparam int HOLD_EFF = (HOLDOFF < 1) ? 1 : HOLDOFF;
    localparam int CNT_MAXV = (HOLDOFF > MAXHOLD) ? HOLDOFF : MAXHOLD;
    localparam int CW       = $clog2(CNT_MAXV) + 1;

    localparam logic [CW-1:0] GRANT_LAST = CW'(MAXHOLD - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_EFF - 1);
    localparam logic [CW-1:0] CNT_SAT    = {CW{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_WAIT_BUS = 3'd2,
        ST_GRANT    = 3'd3,
        ST_RELEASE  = 3'd4,
        ST_HOLDOFF  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovr_q, ovr_d;
    logic [CW-1:0] cnt_inc;

    // Saturating increment so a long stay never wraps the counter.
    assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);

    // State, tenure/holdoff counter and ovr pulse registers; reset drops the grant at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state logic; nothing moves without cpu_cen, and ovr falls back to 0 every clk.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovr_d   = 1'b0;
        if (cpu_cen) begin
            case (state_q)
                ST_IDLE: begin
                    if (per_req) state_d = ST_REQ;
                end
                ST_REQ: begin
                    if (!per_req)  state_d = ST_IDLE;
                    else if (!BGn) state_d = ST_WAIT_BUS;
                end
                ST_WAIT_BUS: begin
                    // The CPU may still be finishing a bus cycle after granting: wait for AS high.
                    if (!BGn && ASn) begin
                        state_d = ST_GRANT;
                        cnt_d   = '0;
                    end
                end
                ST_GRANT: begin
                    cnt_d = cnt_inc;
                    // Voluntary release takes priority over the forced one.
                    if (!per_req) begin
                        state_d = ST_RELEASE;
                    end else if (cnt_q == GRANT_LAST) begin
                        state_d = ST_RELEASE;
                        ovr_d   = 1'b1;
                    end
                end
                ST_RELEASE: begin
                    state_d = ST_HOLDOFF;
                    cnt_d   = '0;
                end
                ST_HOLDOFF: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Bus signals decoded from the registered state, so they change on the same edge as the state.
    always_comb begin
        BRn     = !((state_q == ST_REQ) || (state_q == ST_WAIT_BUS));
        BGACKn  = !((state_q == ST_GRANT) || (state_q == ST_RELEASE));
        per_gnt = (state_q == ST_GRANT);
        busy    = (state_q != ST_IDLE);
        ovr     = ovr_q;
    end

endmodule

// File: tb/tb_jts16_busarb.sv
module tb_jts16_busarb;

    localparam int HOLDOFF = 4;
    localparam int MAXHOLD = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cpu_cen = 1'b0;
    logic ASn = 1'b1;
    logic BGn = 1'b1;
    logic per_req = 1'b0;
    logic BRn, BGACKn, per_gnt, ovr, busy;

    jts16_busarb #(.HOLDOFF(HOLDOFF), .MAXHOLD(MAXHOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cpu_cen (cpu_cen),
        .ASn     (ASn),
        .BGn     (BGn),
        .BRn     (BRn),
        .BGACKn  (BGACKn),
        .per_req (per_req),
        .per_gnt (per_gnt),
        .ovr     (ovr),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int clk_n    = 0;
    int ovr_cnt  = 0;
    bit rand_cen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Reference model: who holds the bus, counted in cpu_cen ticks.
    localparam int P_CPU = 0, P_ASK = 1, P_WAITBUS = 2, P_OWN = 3, P_DRAIN = 4, P_COOL = 5;
    int ph = P_CPU;
    int own_ticks = 0;
    int cool_left = 0;
    bit m_ovr = 1'b0;

    task automatic model_step();
        m_ovr = 1'b0;
        if (!rst_n) begin
            ph = P_CPU;
            return;
        end
        if (!cpu_cen) return;
        case (ph)
            P_CPU:     if (per_req) ph = P_ASK;
            P_ASK:     if (!per_req) ph = P_CPU; else if (!BGn) ph = P_WAITBUS;
            P_WAITBUS: if (!BGn && ASn) begin ph = P_OWN; own_ticks = 0; end
            P_OWN: begin
                own_ticks++;
                if (!per_req) ph = P_DRAIN;
                else if (own_ticks == MAXHOLD) begin ph = P_DRAIN; m_ovr = 1'b1; end
            end
            P_DRAIN: begin
                ph = P_COOL;
                cool_left = (HOLDOFF < 1) ? 1 : HOLDOFF;
            end
            default: begin
                cool_left--;
                if (cool_left == 0) ph = P_CPU;
            end
        endcase
    endtask

    task automatic compare();
        chk("BRn",    BRn,    (ph == P_ASK || ph == P_WAITBUS) ? 0 : 1);
        chk("BGACKn", BGACKn, (ph == P_OWN || ph == P_DRAIN) ? 0 : 1);
        chk("per_gnt", per_gnt, (ph == P_OWN) ? 1 : 0);
        chk("busy",   busy,   (ph != P_CPU) ? 1 : 0);
        chk("ovr",    ovr,    m_ovr);
        chk("inv_gnt_bgack", per_gnt && BGACKn, 0);
        chk("inv_br_bgack", !BRn && !BGACKn, 0);
        if (ovr) ovr_cnt++;
    endtask

    // One clk: model follows the DUT edge, outputs compared on the falling edge, next cen chosen.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        clk_n++;
        cpu_cen = rand_cen ? ($urandom_range(0, 2) == 0) : ((clk_n % 4) == 0);
    endtask

    task automatic cen_ticks(input int n);
        int k = 0;
        while (k < n) begin
            if (cpu_cen) k++;
            tick();
        end
    endtask

    initial begin
        int t;
        int g;
        int ovr_before;

        // Reset state
        repeat (3) tick();
        chk("rst_BRn", BRn, 1);
        chk("rst_BGACKn", BGACKn, 1);
        chk("rst_per_gnt", per_gnt, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        cen_ticks(3);
        chk("idle_no_req", busy, 0);

        // Grant latency with BGn already low and ASn high
        per_req = 1'b1; BGn = 1'b0; ASn = 1'b1;
        t = 0;
        do begin cen_ticks(1); t++; end while (!per_gnt && t < 10);
        chk("latency", t, 3);
        chk("grant_BRn", BRn, 1);
        chk("grant_BGACKn", BGACKn, 0);

        // Overrun: per_req held, tenure cut at MAXHOLD
        ovr_before = ovr_cnt;
        g = 0;
        do begin cen_ticks(1); g++; end while (per_gnt && g < 20);
        chk("tenure", g, MAXHOLD);
        chk("ovr_pulses", ovr_cnt - ovr_before, 1);
        chk("release_BGACKn", BGACKn, 0);
        t = 0;
        do begin cen_ticks(1); t++; end while (BRn && t < 20);
        chk("rearm", t, HOLDOFF + 2);

        // Withdrawal while in REQ
        per_req = 1'b0; BGn = 1'b1;
        cen_ticks(1);
        chk("wd_BRn", BRn, 1);
        chk("wd_busy", busy, 0);
        chk("wd_gnt", per_gnt, 0);

        // CPU still in a bus cycle after granting
        per_req = 1'b1; BGn = 1'b0; ASn = 1'b0;
        cen_ticks(2);
        chk("bw_BRn", BRn, 0);
        for (int i = 0; i < 5; i++) begin
            cen_ticks(1);
            chk("bw_gnt_low", per_gnt, 0);
        end
        ASn = 1'b1;
        cen_ticks(1);
        chk("bw_gnt_high", per_gnt, 1);

        // Reset mid-grant drops the grant immediately
        rst_n = 1'b0;
        #1;
        chk("mrst_BGACKn", BGACKn, 1);
        chk("mrst_gnt", per_gnt, 0);
        chk("mrst_busy", busy, 0);
        ph = P_CPU;
        m_ovr = 1'b0;
        tick();
        rst_n = 1'b1;
        per_req = 1'b0;
        cen_ticks(3);
        chk("mrst_idle", busy, 0);
        per_req = 1'b1;
        cen_ticks(1);
        chk("mrst_req_busy", busy, 1);
        chk("mrst_req_BRn", BRn, 0);

        // Random traffic against the model
        rand_cen = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 15) == 0) per_req = ~per_req;
            if ($urandom_range(0, 7) == 0)  BGn = ~BGn;
            ASn = $urandom_range(0, 1);
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 3999) == 0) rst_n = 1'b0;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
